// File: rtl/message_frame_ctrl.sv
// Message frame controller.
// Collects four data bytes and one check byte, verifies the two's-complement checksum,
// and hands the result downstream under a valid/ready handshake. A partial frame that
// stalls for TIMEOUT idle cycles is discarded with a one-cycle timeout_pulse.
//
// Ports:
//   clk           - clock, all state updates on the rising edge
//   rst_n         - asynchronous active-low reset
//   byte_in       - serial frame byte (4 data bytes, then the check byte)
//   byte_valid    - byte_in valid this cycle
//   byte_ready    - controller accepts a byte this cycle (only while collecting)
//   frame_data    - checked frame, byte0 in [31:24]; zero for a bad frame
//   frame_valid   - frame result available
//   frame_err     - checksum mismatch, qualified by frame_valid
//   out_ready     - downstream accepts the frame result
//   timeout_pulse - one-cycle pulse when a partial frame is aborted
//   err_count     - bad frames delivered, saturating at 255
//   good_count    - good frames delivered, wrapping modulo 256
module message_frame_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic        frame_err,
  input  logic        out_ready,
  output logic        timeout_pulse,
  output logic [7:0]  err_count,
  output logic [7:0]  good_count
);

  typedef enum logic [1:0] {StCollect, StCheck, StOutput} state_e;

  localparam logic [8:0] TimeoutW = 9'(TIMEOUT);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      gap_q, gap_d;
  logic [3:0][7:0] bytes_q, bytes_d;
  logic [7:0]      chk_q, chk_d;
  logic [31:0]     frame_data_q, frame_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            tpulse_q, tpulse_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      good_q, good_d;

  logic            accept;
  logic [8:0]      gap_inc;
  logic [7:0]      sum;
  logic [7:0]      csum;

  assign byte_ready = (state_q == StCollect);
  assign accept     = byte_valid && byte_ready;
  // One bit wider so the compare against TIMEOUT = 255 cannot wrap.
  assign gap_inc    = {1'b0, gap_q} + 9'd1;
  assign sum        = bytes_q[0] + bytes_q[1] + bytes_q[2] + bytes_q[3];
  assign csum       = 8'd0 - sum;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    bytes_d       = bytes_q;
    chk_d         = chk_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_err_d   = frame_err_q;
    tpulse_d      = 1'b0;
    err_d         = err_q;
    good_d        = good_q;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          gap_d = '0;
          if (idx_q == 3'd4) begin
            chk_d   = byte_in;
            idx_d   = '0;
            state_d = StCheck;
          end else begin
            bytes_d[idx_q[1:0]] = byte_in;
            idx_d               = idx_q + 3'd1;
          end
        end else if (idx_q != 3'd0) begin
          if (gap_inc == TimeoutW) begin
            // Stalled partial frame: drop everything collected so far.
            idx_d    = '0;
            gap_d    = '0;
            bytes_d  = '0;
            chk_d    = '0;
            tpulse_d = 1'b1;
          end else begin
            gap_d = gap_inc[7:0];
          end
        end else begin
          gap_d = '0;
        end
      end
      StCheck: begin
        frame_valid_d = 1'b1;
        if (csum == chk_q) begin
          frame_data_d = {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]};
          frame_err_d  = 1'b0;
        end else begin
          frame_data_d = '0;
          frame_err_d  = 1'b1;
        end
        state_d = StOutput;
      end
      StOutput: begin
        if (out_ready) begin
          frame_valid_d = 1'b0;
          frame_err_d   = 1'b0;
          frame_data_d  = '0;
          idx_d         = '0;
          gap_d         = '0;
          state_d       = StCollect;
          if (frame_err_q) begin
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      idx_q         <= '0;
      gap_q         <= '0;
      bytes_q       <= '0;
      chk_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      tpulse_q      <= 1'b0;
      err_q         <= '0;
      good_q        <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      bytes_q       <= bytes_d;
      chk_q         <= chk_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      tpulse_q      <= tpulse_d;
      err_q         <= err_d;
      good_q        <= good_d;
    end
  end

  assign frame_data    = frame_data_q;
  assign frame_valid   = frame_valid_q;
  assign frame_err     = frame_err_q;
  assign timeout_pulse = tpulse_q;
  assign err_count     = err_q;
  assign good_count    = good_q;

endmodule

// File: doc/message_frame_ctrl.md
MESSAGE_FRAME_CTRL -- requirements
Module: message_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: idle cycles allowed between bytes of a partial frame before the frame is aborted (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 byte_in  input  8  serial frame byte: 4 data bytes, then 1 checksum byte.
REQ-005 byte_valid  input  1  byte_in valid this cycle.
REQ-006 byte_ready  output  1  controller can accept a byte this cycle.
REQ-007 frame_data  output  32  checked frame; byte0 in [31:24], byte3 in [7:0].
REQ-008 frame_valid  output  1  frame result available.
REQ-009 frame_err  output  1  checksum mismatch; qualified by frame_valid.
REQ-010 out_ready  input  1  downstream accepts the frame result.
REQ-011 timeout_pulse  output  1  one-cycle pulse when a partial frame is aborted.
REQ-012 err_count  output  8  count of checksum-failed frames; saturates at 255.
REQ-013 good_count  output  8  count of delivered good frames; wraps from 255 to 0.

Function
REQ-014 FSM states SHALL be COLLECT, CHECK, and OUTPUT; reset state is COLLECT.
REQ-015 byte_ready SHALL be 1 only in COLLECT; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-016 A 3-bit byte index SHALL select the storage slot for each accepted byte: indices 0..3 store data bytes 0..3; index 4 stores the check byte and moves COLLECT to CHECK.
REQ-017 CHECK SHALL last exactly one cycle and SHALL compute csum = (two's complement of (b0+b1+b2+b3) mod 256), using 8-bit arithmetic with carries discarded.
REQ-018 The frame is good iff csum equals the check byte.
REQ-019 Good frame behaviour SHALL be: frame_data = {b0,b1,b2,b3}, frame_err = 0.
REQ-020 Bad frame behaviour SHALL be: frame_data = 0, frame_err = 1.
REQ-021 In both cases CHECK SHALL move to OUTPUT with frame_valid = 1.
REQ-022 Latency: if the check byte is accepted in cycle N, frame_valid SHALL be 1 from cycle N+2.
REQ-023 In OUTPUT, frame_valid, frame_err and frame_data SHALL stay stable until out_ready = 1.
REQ-024 On the out_ready = 1 transfer cycle, the FSM SHALL return to COLLECT with byte index 0.
REQ-025 In that next cycle, frame_valid SHALL be 0 and byte_ready SHALL be 1.
REQ-026 err_count SHALL increment on the transfer of a bad frame, and SHALL hold at 255 if already 255.
REQ-027 good_count SHALL increment (mod 256) on the transfer of a good frame.
REQ-028 Gap counter: in COLLECT with byte index 1..4, the counter SHALL increment each cycle with no accepted byte; it SHALL clear on every accepted byte and whenever the byte index is 0.
REQ-029 When the gap counter reaches TIMEOUT with no byte accepted that cycle:
  - partial bytes discarded;
  - byte index set to 0;
  - gap counter cleared;
  - timeout_pulse = 1 for exactly one cycle.
REQ-030 If a byte is accepted in the same cycle the gap counter would reach TIMEOUT, the byte SHALL be accepted and no timeout SHALL occur.
REQ-031 No timeout SHALL occur with byte index 0, in CHECK, or in OUTPUT.
REQ-032 Bytes presented while byte_ready = 0 SHALL be ignored and SHALL NOT be stored.

Reset
REQ-033 While rst_n = 0, regardless of clk:
  - state = COLLECT, byte index = 0, gap counter = 0;
  - byte_ready = 1 (once rst_n = 1);
  - frame_valid = 0, frame_err = 0, frame_data = 0;
  - timeout_pulse = 0, err_count = 0, good_count = 0;
  - stored bytes = 0.
REQ-034 Reset asserted mid-frame or in OUTPUT SHALL discard all partial and pending results, and counters SHALL NOT update.

Verification
REQ-035 Good frame: send 48 45 4C 4C DB back-to-back with out_ready = 1 -> frame_valid 2 cycles after the DB byte, frame_data = 0x48454C4C, frame_err = 0, good_count = 1.
REQ-036 Bad frame: send 48 45 4C 4C DA -> frame_valid = 1, frame_err = 1, frame_data = 0, err_count = 1, good_count unchanged.
REQ-037 Zero frame and backpressure: send 00 00 00 00 00 with out_ready = 0 for 5 cycles -> good frame; frame_valid and frame_data stable and byte_ready = 0 throughout; one transfer on out_ready = 1; byte_ready = 1 next cycle.
REQ-038 Timeout (TIMEOUT = 8): send 11 22, then idle 8 cycles -> one timeout_pulse; then send 48 45 4C 4C DB -> good frame 0x48454C4C.
REQ-039 Timeout boundary (TIMEOUT = 8): send 11, idle 7 cycles, then send a byte in the 8th cycle -> no timeout_pulse, and the byte is stored as b1.
REQ-040 Reset and saturation: assert rst_n = 0 after 3 bytes -> all outputs are at reset values and the next 5 bytes form a fresh frame; 256 bad frames -> err_count = 255 and it stays at 255.
